// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, ALU encodings, FSM states and instruction field positions
package cpu_pkg;
  localparam logic [7:0] OP_MOVI = 8'h00;
  localparam logic [7:0] OP_MOVR = 8'h01;
  localparam logic [7:0] OP_ADD  = 8'h02;
  localparam logic [7:0] OP_SUB  = 8'h03;
  localparam logic [7:0] OP_AND  = 8'h04;
  localparam logic [7:0] OP_OR   = 8'h05;
  localparam logic [2:0] ALU_MOV    = 3'b000;
  localparam logic [2:0] ALU_ADDSUB = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 24;
  localparam int RD_MSB  = 23;
  localparam int RD_LSB  = 16;
  localparam int RS1_MSB = 15;
  localparam int RS1_LSB = 8;
  localparam int RS2_MSB = 7;
  localparam int RS2_LSB = 0;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;
endpackage

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: instruction-memory fetch handshake between controller and memory
interface cpu_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  modport master(output req, addr, input ack, data);
  modport slave(input req, addr, output ack, data);
endinterface

// File: rtl/cpu_decode.sv
// cpu_decode: combinational opcode to ALU control mapping
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [2:0] alu_op,
  output logic       immediate_flag,
  output logic       add_flag,
  output logic       legal
);
  always_comb begin
    legal          = opcode <= OP_OR;
    immediate_flag = opcode == OP_MOVI;
    add_flag       = opcode != OP_SUB;
    alu_op         = (opcode == OP_ADD || opcode == OP_SUB) ? ALU_ADDSUB :
                     opcode == OP_AND ? ALU_AND :
                     opcode == OP_OR  ? ALU_OR  : ALU_MOV;
  end
endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: fetch/decode/exec/writeback controller with sticky halt on illegal opcode
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  cpu_ctrl_if.master        imem,
  output logic [31:0]       pc,
  output logic [2:0]        alu_op,
  output logic              immediate_flag,
  output logic              add_flag,
  output logic              rf_we,
  output logic [7:0]        rd_addr,
  output logic [7:0]        rs1_addr,
  output logic [7:0]        rs2_addr,
  output logic [7:0]        imm,
  output logic              halted
);
  state_t      r_state;
  logic [31:0] r_pc, r_ir;
  logic [2:0]  r_alu_op;
  logic        r_imm_flag, r_add_flag, r_we, r_halted;
  logic [7:0]  w_op;
  logic [2:0]  w_alu_op;
  logic        w_imm_flag, w_add_flag, w_legal;
  // decoding the incoming word at accept makes controls visible already in DECODE
  assign w_op = r_state == FETCH ? imem.data[OPC_MSB:OPC_LSB] : r_ir[OPC_MSB:OPC_LSB];
  cpu_decode u_decode (
    .opcode(w_op), .alu_op(w_alu_op), .immediate_flag(w_imm_flag),
    .add_flag(w_add_flag), .legal(w_legal)
  );
  assign imem.req       = r_state == FETCH && !rst;
  assign imem.addr      = r_pc;
  assign pc             = r_pc;
  assign alu_op         = r_alu_op;
  assign immediate_flag = r_imm_flag;
  assign add_flag       = r_add_flag;
  assign rf_we          = r_we;
  assign halted         = r_halted;
  assign rd_addr        = r_ir[RD_MSB:RD_LSB];
  assign rs1_addr       = r_ir[RS1_MSB:RS1_LSB];
  assign rs2_addr       = r_ir[RS2_MSB:RS2_LSB];
  assign imm            = r_ir[RS2_MSB:RS2_LSB];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_alu_op   <= ALU_MOV;
      r_imm_flag <= 1'b0;
      r_add_flag <= 1'b1;
      r_we       <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        FETCH: if (imem.ack) begin
          r_ir       <= imem.data;
          r_alu_op   <= w_alu_op;
          r_imm_flag <= w_imm_flag;
          r_add_flag <= w_add_flag;
          r_state    <= DECODE;
        end
        DECODE: begin
          r_halted <= ~w_legal;
          r_state  <= w_legal ? EXEC : HALT;
        end
        EXEC: begin
          r_we    <= 1'b1;
          r_state <= WB;
        end
        WB: begin
          r_pc    <= r_pc + 32'd4;
          r_state <= FETCH;
        end
        default: r_state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: randomized instruction stream checked against a per-instruction timing model
module tb_cpu_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cpu_ctrl_if imem();
  cpu_ctrl_if imem2();
  logic [31:0] pc, pc2;
  logic [2:0]  alu_op, alu_op2;
  logic        immediate_flag, add_flag, rf_we, halted;
  logic        immediate_flag2, add_flag2, rf_we2, halted2;
  logic [7:0]  rd_addr, rs1_addr, rs2_addr, imm;
  logic [7:0]  rd_addr2, rs1_addr2, rs2_addr2, imm2;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_pc;
  logic [31:0] w, r;
  int          d;
  cpu_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem(imem), .pc(pc), .alu_op(alu_op),
    .immediate_flag(immediate_flag), .add_flag(add_flag), .rf_we(rf_we),
    .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .imm(imm), .halted(halted)
  );
  cpu_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .imem(imem2), .pc(pc2), .alu_op(alu_op2),
    .immediate_flag(immediate_flag2), .add_flag(add_flag2), .rf_we(rf_we2),
    .rd_addr(rd_addr2), .rs1_addr(rs1_addr2), .rs2_addr(rs2_addr2), .imm(imm2), .halted(halted2)
  );
  assign imem2.ack  = imem2.req;
  assign imem2.data = 32'h0203_0102;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // {legal, alu_op, immediate_flag, add_flag} straight from the opcode table
  function automatic logic [5:0] exp_ctl(input logic [7:0] op);
    case (op)
      8'h00: return 6'b1_000_1_1;
      8'h01: return 6'b1_000_0_1;
      8'h02: return 6'b1_001_0_1;
      8'h03: return 6'b1_001_0_0;
      8'h04: return 6'b1_010_0_1;
      8'h05: return 6'b1_011_0_1;
      default: return 6'b0_000_0_1;
    endcase
  endfunction
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    imem.ack = 1'b1;
    imem.data = $urandom;
    repeat (cycles) begin
      step();
      chk("rst_req", {31'd0, imem.req}, 0);
      chk("rst_pc", pc, 0);
      chk("rst_we", {31'd0, rf_we}, 0);
      chk("rst_halted", {31'd0, halted}, 0);
      chk("rst_ctl", {27'd0, alu_op, immediate_flag, add_flag}, 32'h1);
      chk("rst_fields", {rd_addr, rs1_addr, rs2_addr, imm}, 0);
    end
    rst = 1'b0;
    imem.ack = 1'b0;
    #1;
    chk("rel_req", {31'd0, imem.req}, 1);
    chk("rel_addr", imem.addr, 0);
    m_pc = 32'd0;
  endtask
  task automatic run(input logic [31:0] word, input int dly);
    logic [5:0] e;
    e = exp_ctl(word[31:24]);
    repeat (dly) begin
      chk("wait_req", {31'd0, imem.req}, 1);
      chk("wait_addr", imem.addr, m_pc);
      chk("wait_pc", pc, m_pc);
      chk("wait_we", {31'd0, rf_we}, 0);
      imem.ack = 1'b0;
      imem.data = $urandom;
      step();
    end
    chk("fetch_req", {31'd0, imem.req}, 1);
    chk("fetch_addr", imem.addr, m_pc);
    imem.ack = 1'b1;
    imem.data = word;
    step();
    if (!e[5]) begin
      repeat (20) begin
        imem.ack = 1'($urandom_range(0, 1));
        imem.data = $urandom;
        step();
        chk("halt_flag", {31'd0, halted}, 1);
        chk("halt_we", {31'd0, rf_we}, 0);
        chk("halt_pc", pc, m_pc);
        chk("halt_req", {31'd0, imem.req}, 0);
      end
      imem.ack = 1'b0;
      return;
    end
    for (int k = 0; k < 3; k++) begin
      chk("ctl", {27'd0, alu_op, immediate_flag, add_flag}, {27'd0, e[4:0]});
      chk("fields", {8'd0, rd_addr, rs1_addr, rs2_addr}, {8'd0, word[23:0]});
      chk("imm", {24'd0, imm}, {24'd0, word[7:0]});
      chk("pc", pc, m_pc);
      chk("we", {31'd0, rf_we}, k == 2 ? 32'd1 : 32'd0);
      chk("busy_req", {31'd0, imem.req}, 0);
      chk("halted", {31'd0, halted}, 0);
      imem.ack = 1'($urandom_range(0, 1));
      imem.data = $urandom;
      step();
    end
    imem.ack = 1'b0;
    m_pc = m_pc + 32'd4;
    chk("pc_next", pc, m_pc);
    chk("we_after", {31'd0, rf_we}, 0);
    chk("req_again", {31'd0, imem.req}, 1);
  endtask
  initial begin
    imem.ack = 1'b0;
    imem.data = '0;
    m_pc = '0;
    do_reset(2);
    chk("wrap_rst_pc", pc2, 32'hFFFF_FFFC);
    repeat (3) step();
    chk("wrap_wb_pc", pc2, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc", pc2, 32'h0000_0000);
    run(32'h0203_0102, 0);
    run(32'h0005_007F, 0);
    w = $urandom;
    run({8'h03, w[23:0]}, 0);
    w = $urandom;
    run({8'h04, w[23:0]}, 5);
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      w[31:24] = 8'($urandom_range(0, 5));
      d = $urandom_range(0, 3);
      run(w, d);
    end
    run(32'h2A11_2233, 1);
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      w[31:24] = 8'($urandom_range(6, 255));
      run(w, 0);
      do_reset($urandom_range(1, 2));
    end
    run(32'h0101_0203, 0);
    imem.ack = 1'b0;
    repeat (2) step();
    do_reset(1);
    run(32'h0203_0405, 0);
    imem.ack = 1'b1;
    imem.data = 32'h0207_0809;
    step();
    imem.ack = 1'b0;
    step();
    do_reset(1);
    step();
    chk("abort_we", {31'd0, rf_we}, 0);
    chk("abort_addr", imem.addr, 32'd0);
    r = $urandom;
    run({8'h05, r[23:0]}, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
